// File: rtl/gpio_ram_logger.sv
// -----------------------------------------------------------------------------
// gpio_ram_logger
//
// GPIO command decoder and capture RAM for the DSP datapath.
//
// A 32-bit command frame from the processor GPIO is registered every cycle and
// decoded from that registered copy (level based: a held frame keeps acting).
// Frame layout: [31:24] cmd, [23] en, [22:0] payload.
//
//   cmd 0x01  o_dsp_reset  <= payload[0]   (held while other commands run)
//   cmd 0x02  o_enb_adapt  <= payload[0]   (held while other commands run)
//   cmd 0x03  capture control: payload[3] arm, payload[2:0] channel (1..N_CH),
//             payload[15:8] decimation D (store every (D+1)-th valid sample)
//   cmd 0x04  read RAM[payload[NB_ADDR-1:0]] when payload[16]=1,
//             returned sign-extended to 32 bits
//   cmd 0x05  status: [31] done, [30] logging, [29:27] channel,
//             [16:0] write count
//   anything else (or en=0) is a NOP and the response is 0.
//
// Capture FSM: IDLE -> LOG on the arming frame; LOG -> DONE once 2^NB_ADDR
// samples are stored; LOG/DONE -> IDLE as soon as the registered frame differs
// from the frame that armed the capture. Count and channel survive an abort.
//
// Ports:
//   clockdsp                  in   single clock, rising edge
//   i_reset                   in   synchronous active-high reset
//   gpio_output_to_input_dsp  in   32-bit command frame
//   gpio_input_to_output_dsp  out  32-bit response word (3 edges after frame)
//   i_ch_data                 in   N_CH packed streams, stream k at [k*NB_DATA +: NB_DATA]
//   i_ch_valid                in   per-stream sample strobe
//   o_dsp_reset               out  DSP core reset request
//   o_enb_adapt               out  adaptive filter enable
//   o_logging                 out  high while the FSM is in LOG
//
// Stream strobes carry no backpressure: a sample is taken on every edge where
// its i_ch_valid bit is high, and the logger never stalls the source.
// -----------------------------------------------------------------------------
module gpio_ram_logger #(
    parameter int NB_DATA = 16,
    parameter int N_CH    = 4,
    parameter int NB_ADDR = 15
) (
    input  logic                     clockdsp,
    input  logic                     i_reset,
    input  logic [31:0]              gpio_output_to_input_dsp,
    output logic [31:0]              gpio_input_to_output_dsp,
    input  logic [N_CH*NB_DATA-1:0]  i_ch_data,
    input  logic [N_CH-1:0]          i_ch_valid,
    output logic                     o_dsp_reset,
    output logic                     o_enb_adapt,
    output logic                     o_logging
);

    localparam logic [7:0] CMD_DSP_RESET = 8'h01;
    localparam logic [7:0] CMD_ENB_ADAPT = 8'h02;
    localparam logic [7:0] CMD_CAPTURE   = 8'h03;
    localparam logic [7:0] CMD_READ      = 8'h04;
    localparam logic [7:0] CMD_STATUS    = 8'h05;

    localparam int         DEPTH      = 1 << NB_ADDR;
    localparam logic [2:0] N_CH_LIMIT = 3'(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOG  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE   = 2'd0,
        RESP_READ   = 2'd1,
        RESP_STATUS = 2'd2
    } resp_t;

    // -------------------------------------------------------------------------
    // Frame register and field decode
    // -------------------------------------------------------------------------
    logic [31:0] frame_q;
    logic [7:0]  cmd;
    logic        en;

    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= gpio_output_to_input_dsp;
        end
    end

    assign cmd = frame_q[31:24];
    assign en  = frame_q[23];

    // -------------------------------------------------------------------------
    // Level-held control outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            o_dsp_reset <= 1'b0;
            o_enb_adapt <= 1'b0;
        end else begin
            if (en && (cmd == CMD_DSP_RESET)) begin
                o_dsp_reset <= frame_q[0];
            end
            if (en && (cmd == CMD_ENB_ADAPT)) begin
                o_enb_adapt <= frame_q[0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Capture state
    // -------------------------------------------------------------------------
    state_t              state;
    state_t              state_next;
    logic                start;
    logic [31:0]         arm_frame_q;   // frame that armed the current capture
    logic [2:0]          ch_q;          // latched channel, 1-based
    logic [7:0]          dec_cnt;
    logic [NB_ADDR-1:0]  wr_ptr;
    logic [NB_ADDR:0]    count;
    logic                ch_ok;
    logic                arm_req;
    logic                frame_held;
    logic [NB_DATA-1:0]  sel_data;
    logic                sel_valid;
    logic                sample_take;
    logic                wr_en;

    assign ch_ok      = (frame_q[2:0] != 3'd0) && (frame_q[2:0] <= N_CH_LIMIT);
    assign arm_req    = en && (cmd == CMD_CAPTURE) && frame_q[3] && ch_ok;
    // Any change of the registered frame, including channel or D, ends capture.
    assign frame_held = (frame_q == arm_frame_q);

    // Stream selection by the latched 1-based channel; ch_q=0 selects nothing.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == 3'(k + 1)) begin
                sel_data  = i_ch_data[k*NB_DATA +: NB_DATA];
                sel_valid = i_ch_valid[k];
            end
        end
    end

    assign sample_take = (state == ST_LOG) && frame_held && sel_valid;
    assign wr_en       = sample_take && (dec_cnt == 8'd0);

    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arm_req) begin
                    start      = 1'b1;
                    state_next = ST_LOG;
                end
            end
            ST_LOG: begin
                if (!frame_held) begin
                    state_next = ST_IDLE;
                end else if (wr_en && (wr_ptr == '1)) begin
                    // This write fills the last RAM slot.
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!frame_held) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counters. Count and channel are only cleared by reset or a new arming,
    // so status still reports them after an abort.
    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            arm_frame_q <= '0;
            ch_q        <= '0;
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (start) begin
            arm_frame_q <= frame_q;
            ch_q        <= frame_q[2:0];
            dec_cnt     <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (sample_take) begin
            if (dec_cnt == arm_frame_q[15:8]) begin
                dec_cnt <= '0;
            end else begin
                dec_cnt <= dec_cnt + 8'd1;
            end
            if (wr_en) begin
                count <= count + 1'b1;
                // Pointer parks on the last slot instead of wrapping.
                if (wr_ptr != '1) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    assign o_logging = (state == ST_LOG);

    // -------------------------------------------------------------------------
    // Capture RAM: write port from the FSM, registered read port from cmd 0x04.
    // Non-blocking read alongside the write returns old data on a collision.
    // -------------------------------------------------------------------------
    logic [NB_DATA-1:0] mem [0:DEPTH-1];
    logic [NB_DATA-1:0] rd_data;

    always_ff @(posedge clockdsp) begin
        if (wr_en) begin
            mem[wr_ptr] <= sel_data;
        end
        rd_data <= mem[frame_q[NB_ADDR-1:0]];
    end

    // -------------------------------------------------------------------------
    // Response path: stage 2 captures RAM word / status, stage 3 drives GPIO.
    // -------------------------------------------------------------------------
    resp_t                      resp_kind_q;
    logic [31:0]                status_q;
    logic [31:0]                status_word;
    logic signed [NB_DATA-1:0]  rd_signed;

    assign status_word = {(state == ST_DONE), (state == ST_LOG), ch_q, 10'd0, 17'(count)};
    assign rd_signed   = rd_data;

    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            resp_kind_q <= RESP_NONE;
            status_q    <= '0;
        end else begin
            status_q <= status_word;
            if (en && (cmd == CMD_READ) && frame_q[16]) begin
                resp_kind_q <= RESP_READ;
            end else if (en && (cmd == CMD_STATUS)) begin
                resp_kind_q <= RESP_STATUS;
            end else begin
                resp_kind_q <= RESP_NONE;
            end
        end
    end

    always_ff @(posedge clockdsp) begin
        if (i_reset) begin
            gpio_input_to_output_dsp <= '0;
        end else begin
            unique case (resp_kind_q)
                RESP_READ:   gpio_input_to_output_dsp <= 32'(rd_signed);
                RESP_STATUS: gpio_input_to_output_dsp <= status_q;
                default:     gpio_input_to_output_dsp <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_ram_logger.sv
// -----------------------------------------------------------------------------
// tb_gpio_ram_logger
//
// Directed bench for gpio_ram_logger with a 16-entry RAM (NB_ADDR=4).
// A table of frames with expected control outputs covers command decode; the
// capture, decimation, abort, invalid-channel and mid-capture reset cases are
// hand-written sequences. Inputs change 1 time unit after each rising edge and
// outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_gpio_ram_logger;

    localparam int NB_DATA = 16;
    localparam int N_CH    = 4;
    localparam int NB_ADDR = 4;

    // ---------------- clock / reset ----------------
    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              frame;
    logic [31:0]              resp;
    logic [N_CH*NB_DATA-1:0]  ch_data;
    logic [N_CH-1:0]          ch_valid;
    logic                     dsp_reset;
    logic                     enb_adapt;
    logic                     logging;

    always #5 clk = ~clk;

    gpio_ram_logger #(
        .NB_DATA (NB_DATA),
        .N_CH    (N_CH),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clockdsp                 (clk),
        .i_reset                  (rst),
        .gpio_output_to_input_dsp (frame),
        .gpio_input_to_output_dsp (resp),
        .i_ch_data                (ch_data),
        .i_ch_valid               (ch_valid),
        .o_dsp_reset              (dsp_reset),
        .o_enb_adapt              (enb_adapt),
        .o_logging                (logging)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- stream driver ----------------
    logic        ramp_on  = 1'b0;
    int          ramp_ch  = 0;
    logic [15:0] ramp_val = '0;

    task automatic drive_streams();
        for (int c = 0; c < N_CH; c++) begin
            if (ramp_on && (c == ramp_ch)) begin
                ch_data[c*NB_DATA +: NB_DATA] = ramp_val;
                ch_valid[c]                   = 1'b1;
            end else begin
                ch_data[c*NB_DATA +: NB_DATA] = 16'h1230 + 16'(c);
                ch_valid[c]                   = ramp_on & ramp_val[0];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ramp_on) ramp_val = ramp_val + 16'd1;
        drive_streams();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ramp_start(input logic [15:0] base, input int ch);
        ramp_on  = 1'b1;
        ramp_val = base;
        ramp_ch  = ch;
        drive_streams();
    endtask

    task automatic ramp_stop();
        ramp_on = 1'b0;
        drive_streams();
    endtask

    // Drop back to IDLE with a NOP, apply the arming frame, wait until LOG,
    // then start the ramp so its first value is the first stored sample.
    task automatic arm_capture(input logic [31:0] arm, input logic [15:0] base, input int ch);
        ramp_stop();
        frame = 32'h0000_0000;
        ticks(2);
        frame = arm;
        ticks(2);
        ramp_start(base, ch);
    endtask

    task automatic read_word(input int addr, input logic [31:0] exp, input string name);
        frame = 32'h0481_0000 | 32'(addr);
        ticks(3);
        check(name, resp, exp);
    endtask

    task automatic read_status(input logic [31:0] exp, input string name);
        frame = 32'h0580_0000;
        ticks(3);
        check(name, resp, exp);
    endtask

    // ---------------- command table ----------------
    typedef struct {
        logic [31:0] frame;
        int          n_ticks;
        logic        exp_rst;
        logic        exp_enb;
        logic        chk_resp;
        logic [31:0] exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] f, input int n, input logic r,
                                input logic e, input logic cr, input logic [31:0] er,
                                input string nm);
        vec_t v;
        v.frame    = f;
        v.n_ticks  = n;
        v.exp_rst  = r;
        v.exp_enb  = e;
        v.chk_resp = cr;
        v.exp_resp = er;
        v.name     = nm;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] s;

        //                frame         tk rst enb chk resp
        vecs.push_back(mk(32'h0000_0000, 3, 0, 0, 1, 32'h0, "idle_nop"));
        vecs.push_back(mk(32'h0180_0001, 1, 0, 0, 0, 32'h0, "rst_set_1edge"));
        vecs.push_back(mk(32'h0180_0001, 1, 1, 0, 0, 32'h0, "rst_set_2edge"));
        vecs.push_back(mk(32'h0180_0001, 8, 1, 0, 1, 32'h0, "rst_held"));
        vecs.push_back(mk(32'h0180_0000, 1, 1, 0, 0, 32'h0, "rst_clr_1edge"));
        vecs.push_back(mk(32'h0180_0000, 1, 0, 0, 0, 32'h0, "rst_clr_2edge"));
        vecs.push_back(mk(32'h0280_0001, 2, 0, 1, 0, 32'h0, "enb_set"));
        vecs.push_back(mk(32'h0200_0000, 3, 0, 1, 1, 32'h0, "enb_nop_en0"));
        vecs.push_back(mk(32'h0980_0001, 3, 0, 1, 1, 32'h0, "enb_nop_unknown"));
        vecs.push_back(mk(32'h0180_0001, 3, 1, 1, 1, 32'h0, "rst_with_enb"));
        vecs.push_back(mk(32'h0580_0000, 3, 1, 1, 1, 32'h0, "status_after_reset"));
        vecs.push_back(mk(32'h0280_0000, 2, 1, 0, 0, 32'h0, "enb_clr"));
        vecs.push_back(mk(32'h0180_0000, 2, 0, 0, 1, 32'h0, "rst_clr"));

        rst   = 1'b1;
        frame = 32'h0;
        drive_streams();
        ticks(3);
        check("reset_resp",    resp,              32'h0);
        check("reset_logging", {31'd0, logging},  32'h0);
        check("reset_dsp_rst", {31'd0, dsp_reset}, 32'h0);
        rst = 1'b0;

        // Command decode table
        foreach (vecs[i]) begin
            frame = vecs[i].frame;
            ticks(vecs[i].n_ticks);
            check({vecs[i].name, "/dsp_reset"}, {31'd0, dsp_reset}, {31'd0, vecs[i].exp_rst});
            check({vecs[i].name, "/enb_adapt"}, {31'd0, enb_adapt}, {31'd0, vecs[i].exp_enb});
            check({vecs[i].name, "/logging"},   {31'd0, logging},   32'h0);
            if (vecs[i].chk_resp) check({vecs[i].name, "/resp"}, resp, vecs[i].exp_resp);
        end

        // Full capture on ch1, D=0, ramp 0..15
        arm_capture(32'h0380_0009, 16'd0, 0);
        check("cap_logging_start", {31'd0, logging}, 32'h1);
        ticks(15);
        check("cap_logging_15", {31'd0, logging}, 32'h1);
        tick();
        check("cap_logging_full", {31'd0, logging}, 32'h0);
        ramp_stop();
        read_status(32'h8800_0010, "cap_status_done");
        tick();
        check("cap_status_after_abort", resp, 32'h0800_0010);
        for (int i = 0; i < 16; i++) read_word(i, 32'(i), "cap_read");

        // Decimation: ch2, D=2 -> RAM holds 0,3,6,...,45
        arm_capture(32'h0380_020A, 16'd0, 1);
        ticks(45);
        check("dec_logging_45", {31'd0, logging}, 32'h1);
        tick();
        check("dec_logging_full", {31'd0, logging}, 32'h0);
        ramp_stop();
        read_status(32'h9000_0010, "dec_status_done");
        for (int i = 0; i < 16; i++) read_word(i, 32'(3 * i), "dec_read");

        // Sign extension: ramp 0x7FF8..0x8007 on ch1
        arm_capture(32'h0380_0009, 16'h7FF8, 0);
        ticks(16);
        ramp_stop();
        read_word(7,  32'h0000_7FFF, "sext_7fff");
        read_word(8,  32'hFFFF_8000, "sext_8000");
        read_word(15, 32'hFFFF_8007, "sext_8007");

        // Abort after 5 stored samples
        arm_capture(32'h0380_0009, 16'd100, 0);
        ticks(5);
        check("abort_logging_before", {31'd0, logging}, 32'h1);
        ramp_stop();
        frame = 32'h0380_0000;
        ticks(2);
        check("abort_logging_after", {31'd0, logging}, 32'h0);
        read_status(32'h0800_0005, "abort_status");
        read_word(4, 32'd104, "abort_last_write");
        s = 16'h7FFD;
        read_word(5, 32'(s), "abort_ram_retained");
        frame = 32'h0380_0009;
        ticks(2);
        check("rearm_logging", {31'd0, logging}, 32'h1);
        read_status(32'h4800_0000, "rearm_status_cleared");

        // Invalid channels leave the FSM idle and the RAM untouched
        frame = 32'h0380_000F;
        ramp_start(16'd200, 0);
        ticks(4);
        check("inv_ch7_logging", {31'd0, logging}, 32'h0);
        frame = 32'h0380_0008;
        ticks(4);
        check("inv_ch0_logging", {31'd0, logging}, 32'h0);
        ramp_stop();
        read_status(32'h0800_0000, "inv_status");
        read_word(0, 32'd100, "inv_no_write");

        // Reset during LOG
        arm_capture(32'h0380_0009, 16'd300, 0);
        ticks(3);
        check("rst_cap_logging_before", {31'd0, logging}, 32'h1);
        rst = 1'b1;
        tick();
        check("rst_cap_logging_after", {31'd0, logging}, 32'h0);
        rst = 1'b0;
        ramp_stop();
        read_status(32'h0000_0000, "rst_cap_status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
